// File: rtl/stream_mux_arb.sv
// -----------------------------------------------------------------------------
// stream_mux_arb
//
// Merges NUM_CH valid/ready input streams into a single registered output
// stream. In MODE=0 the channel is chosen by the select port, which makes it a
// drop-in replacement for the old select-driven combinational mux. In MODE=1
// a round-robin arbiter picks among the valid channels and select is ignored.
//
// The output register is a one-entry skid-free stage. It can accept a new
// word whenever it is empty or is being drained on the same edge, so
// back-to-back words flow at one per cycle with one cycle of latency.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_data    NUM_CH*WIDTH flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   select     channel index used in MODE=0
//   out_data   registered output word
//   out_valid  output register holds a word
//   out_ready  downstream accepts the word
//   out_ch     index of the channel that produced out_data
//
// Parameter constraints: 2 <= NUM_CH <= 16 and 2**SEL_W >= NUM_CH.
// -----------------------------------------------------------------------------
module stream_mux_arb #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic [SEL_W-1:0]        select,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_ch
);

    localparam int NUM_SLOTS = 2 ** SEL_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   data_reg;
    logic [WIDTH-1:0]   data_next;
    logic [SEL_W-1:0]   ch_reg;
    logic [SEL_W-1:0]   ch_next;
    logic [SEL_W-1:0]   ptr_reg;
    logic [SEL_W-1:0]   ptr_next;

    logic               can_accept;
    logic               transfer;
    logic               grant_valid;
    logic [SEL_W-1:0]   grant_idx;

    logic               sel_grant_valid;
    logic               rr_grant_valid;
    logic [SEL_W-1:0]   rr_grant_idx;

    // Per-channel words and valids are padded out to the full select range so
    // that any SEL_W-bit index is in bounds; the padding slots are never valid.
    logic [WIDTH-1:0]     ch_word [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] valid_pad;

    // Candidate channel index for each round-robin priority position.
    logic [SEL_W:0]     cand_sum [NUM_CH];
    logic [SEL_W-1:0]   cand_idx [NUM_CH];

    // -------------------------------------------------------------------------
    // Channel unpacking
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            if (gi < NUM_CH) begin : g_real
                assign ch_word[gi]   = in_data[gi*WIDTH +: WIDTH];
                assign valid_pad[gi] = in_valid[gi];
            end else begin : g_pad
                assign ch_word[gi]   = '0;
                assign valid_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Select-driven grant: an out-of-range select simply never grants.
    // -------------------------------------------------------------------------
    assign sel_grant_valid = (int'(select) < NUM_CH) && valid_pad[select];

    // -------------------------------------------------------------------------
    // Round-robin grant. Priority position k looks at channel (ptr + k) mod
    // NUM_CH. ptr and k are both below NUM_CH, so a single conditional
    // subtraction is enough for the wrap.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand_sum[gi] = {1'b0, ptr_reg} + (SEL_W+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (SEL_W+1)'(NUM_CH))
                                ? SEL_W'(cand_sum[gi] - (SEL_W+1)'(NUM_CH))
                                : cand_sum[gi][SEL_W-1:0];
        end
    endgenerate

    // Scan from lowest priority to highest so the last hit (position closest
    // to ptr) wins.
    always_comb begin
        rr_grant_valid = 1'b0;
        rr_grant_idx   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (valid_pad[cand_idx[k]]) begin
                rr_grant_valid = 1'b1;
                rr_grant_idx   = cand_idx[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Mode selection and handshake
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (MODE == 0) begin
            grant_valid = sel_grant_valid;
            grant_idx   = select;
        end else begin
            grant_valid = rr_grant_valid;
            grant_idx   = rr_grant_idx;
        end
    end

    assign can_accept = (state_reg == EMPTY) || out_ready;
    assign transfer   = can_accept && grant_valid;

    // Ready is forced low while reset is held so no source sees a handshake
    // against a register that is being cleared.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign in_ready[gi] = !rst && transfer && (grant_idx == SEL_W'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output register next-state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        ch_next    = ch_reg;
        ptr_next   = ptr_reg;

        if (transfer) begin
            // Covers both filling an empty register and drain-and-refill.
            state_next = FULL;
            data_next  = ch_word[grant_idx];
            ch_next    = grant_idx;
            if (MODE != 0) begin
                ptr_next = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (state_reg == FULL && out_ready) begin
            // Drain only: data and channel keep their last values.
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            ch_reg    <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            ch_reg    <= ch_next;
            ptr_reg   <= ptr_next;
        end
    end

    assign out_valid = (state_reg == FULL);
    assign out_data  = data_reg;
    assign out_ch    = ch_reg;

endmodule
